// File: rtl/step_sequencer_if.sv
// Control/status bundle between the front panel, the control unit and the step sequencer.
// The master side drives the run controls and CU strobes; the slave side returns step and status.
interface step_sequencer_if #(
  parameter int STEP_W  = 4,
  parameter int COUNT_W = 16
);
  logic               cpu_run;
  logic               single_step;
  logic               clear_fault;
  logic               SC_inc;
  logic               SC_reset;
  logic               HALT;
  logic [STEP_W-1:0]  step;
  logic               cpu_running;
  logic               halted;
  logic               fault;
  logic               instr_done;
  logic [COUNT_W-1:0] instr_count;

  modport master (
    output cpu_run, single_step, clear_fault, SC_inc, SC_reset, HALT,
    input  step, cpu_running, halted, fault, instr_done, instr_count
  );

  modport slave (
    input  cpu_run, single_step, clear_fault, SC_inc, SC_reset, HALT,
    output step, cpu_running, halted, fault, instr_done, instr_count
  );
endinterface

// File: rtl/step_sequencer.sv
// Instruction step counter for the control unit, wrapped in an idle/run/single-step/halt/fault
// state machine that also counts retired instructions. Every output comes straight from a flop.
module step_sequencer #(
  parameter int STEP_W   = 4,
  parameter int MAX_STEP = 15,
  parameter int COUNT_W  = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  step_sequencer_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RUN    = 3'd1,
    SSTEP  = 3'd2,
    HALTED = 3'd3,
    FAULT  = 3'd4
  } state_t;

  state_t             state_reg, state_next;
  logic [STEP_W-1:0]  step_reg, step_next;
  logic [COUNT_W-1:0] count_reg, count_next;
  logic               done_reg, done_next;
  logic               running_reg, halted_reg, fault_reg;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg   <= IDLE;
      step_reg    <= '0;
      count_reg   <= '0;
      done_reg    <= 1'b0;
      running_reg <= 1'b0;
      halted_reg  <= 1'b0;
      fault_reg   <= 1'b0;
    end else begin
      state_reg   <= state_next;
      step_reg    <= step_next;
      count_reg   <= count_next;
      done_reg    <= done_next;
      // Status flags are decoded from the next state so they line up with step/count.
      running_reg <= (state_next == RUN) || (state_next == SSTEP);
      halted_reg  <= (state_next == HALTED);
      fault_reg   <= (state_next == FAULT);
    end
  end

  always_comb begin
    state_next = state_reg;
    step_next  = step_reg;
    count_next = count_reg;
    done_next  = 1'b0;

    unique case (state_reg)
      IDLE: begin
        if (bus.cpu_run)          state_next = RUN;
        else if (bus.single_step) state_next = SSTEP;
      end

      RUN, SSTEP: begin
        if (bus.HALT) begin
          state_next = HALTED;
        end else if (bus.SC_reset) begin
          step_next  = '0;
          count_next = count_reg + COUNT_W'(1);
          done_next  = 1'b1;
          // A running instruction always completes; dropping cpu_run only takes effect here.
          if (state_reg == SSTEP || !bus.cpu_run) state_next = IDLE;
        end else if (bus.SC_inc) begin
          if (step_reg == STEP_W'(MAX_STEP)) state_next = FAULT;
          else                               step_next  = step_reg + STEP_W'(1);
        end
      end

      FAULT: begin
        if (bus.clear_fault) begin
          state_next = IDLE;
          step_next  = '0;
        end
      end

      HALTED: begin
        state_next = HALTED;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign bus.step        = step_reg;
  assign bus.cpu_running = running_reg;
  assign bus.halted      = halted_reg;
  assign bus.fault       = fault_reg;
  assign bus.instr_done  = done_reg;
  assign bus.instr_count = count_reg;

endmodule

// File: tb/tb_step_sequencer.sv
// Bench for step_sequencer: a directed vector table, hand-written reset and counter-wrap
// sequences, then random strobes checked against a behavioural model of the sequencer.
module tb_step_sequencer;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  step_sequencer_if #(.STEP_W(4), .COUNT_W(16)) bus ();
  step_sequencer_if #(.STEP_W(4), .COUNT_W(4))  bus4 ();

  step_sequencer #(.STEP_W(4), .MAX_STEP(15), .COUNT_W(16)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus)
  );
  step_sequencer #(.STEP_W(4), .MAX_STEP(15), .COUNT_W(4)) dut4 (
    .clk(clk), .reset_n(reset_n), .bus(bus4)
  );

  // The narrow-counter instance sees exactly the same stimulus.
  assign bus4.cpu_run     = bus.cpu_run;
  assign bus4.single_step = bus.single_step;
  assign bus4.clear_fault = bus.clear_fault;
  assign bus4.SC_inc      = bus.SC_inc;
  assign bus4.SC_reset    = bus.SC_reset;
  assign bus4.HALT        = bus.HALT;

  // Input bits: {cpu_run, single_step, clear_fault, SC_inc, SC_reset, HALT}
  localparam logic [5:0] I_RUN = 6'b100000, I_SS = 6'b010000, I_CF = 6'b001000;
  localparam logic [5:0] I_INC = 6'b000100, I_RST = 6'b000010, I_HLT = 6'b000001;
  // Flag bits: {cpu_running, halted, fault, instr_done}
  localparam logic [3:0] F_RUN = 4'b1000, F_HALT = 4'b0100, F_FLT = 4'b0010, F_DONE = 4'b0001;

  typedef struct {
    logic [5:0] in;
    int         step;
    logic [3:0] flags;
    int         count;
  } vec_t;

  vec_t tbl[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Behavioural model: what the sequencer is doing, as plain flags and integers.
  bit m_running, m_single, m_halted, m_faulted, m_done;
  int m_step, m_count;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic add(input logic [5:0] in, input int step, input logic [3:0] flags, input int count);
    vec_t v;
    v.in = in; v.step = step; v.flags = flags; v.count = count;
    tbl.push_back(v);
  endtask

  task automatic drive(input logic [5:0] in);
    {bus.cpu_run, bus.single_step, bus.clear_fault, bus.SC_inc, bus.SC_reset, bus.HALT} = in;
  endtask

  function automatic logic [31:0] observed();
    return {8'h00, bus.step, bus.cpu_running, bus.halted, bus.fault, bus.instr_done, bus.instr_count};
  endfunction

  function automatic logic [31:0] expect_of(input int step, input logic [3:0] flags, input int count);
    logic [3:0]  s;
    logic [15:0] c;
    s = step[3:0];
    c = count[15:0];
    return {8'h00, s, flags, c};
  endfunction

  task automatic check_both(input string name, input int step, input logic [3:0] flags, input int count);
    check(name, observed(), expect_of(step, flags, count));
    check({name, "_c4"}, 32'(bus4.instr_count), 32'(count % 16));
  endtask

  task automatic model_reset();
    m_running = 0; m_single = 0; m_halted = 0; m_faulted = 0; m_done = 0;
    m_step = 0; m_count = 0;
  endtask

  task automatic model_clock(input logic [5:0] in);
    bit cr, ss, cf, inc, rst, hlt;
    {cr, ss, cf, inc, rst, hlt} = in;
    m_done = 0;
    if (m_halted) begin
      // nothing leaves HALTED except reset
    end else if (m_faulted) begin
      if (cf) begin m_faulted = 0; m_step = 0; end
    end else if (!m_running && !m_single) begin
      if (cr) m_running = 1;
      else if (ss) m_single = 1;
    end else if (hlt) begin
      m_halted = 1; m_running = 0; m_single = 0;
    end else if (rst) begin
      m_step = 0; m_count++; m_done = 1;
      if (m_single || !cr) begin m_running = 0; m_single = 0; end
    end else if (inc) begin
      if (m_step == 15) begin m_faulted = 1; m_running = 0; m_single = 0; end
      else m_step++;
    end
  endtask

  task automatic async_reset_check(input string name);
    reset_n = 1'b0;
    #1;
    check_both(name, 0, 4'b0000, 0);
    reset_n = 1'b1;
    model_reset();
  endtask

  initial begin
    logic [5:0] in;
    logic       cr_hold;

    // Run one instruction, then drop cpu_run mid-instruction.
    add(I_RUN, 0, F_RUN, 0);
    for (int i = 1; i <= 7; i++) add(I_RUN | I_INC, i, F_RUN, 0);
    add(I_RUN | I_RST, 0, F_RUN | F_DONE, 1);
    add(I_RUN, 0, F_RUN, 1);
    for (int i = 1; i <= 3; i++) add(I_RUN | I_INC, i, F_RUN, 1);
    for (int i = 4; i <= 7; i++) add(I_INC, i, F_RUN, 1);
    add(I_RST, 0, F_DONE, 2);
    add(I_INC, 0, 4'b0000, 2);
    // Single step, with a second instruction's SC_inc ignored in IDLE.
    add(I_SS, 0, F_RUN, 2);
    for (int i = 1; i <= 5; i++) add(I_INC, i, F_RUN, 2);
    add(I_RST, 0, F_DONE, 3);
    add(I_INC, 0, 4'b0000, 3);
    add(I_INC, 0, 4'b0000, 3);
    // Overrun into FAULT, strobes ignored, then clear_fault.
    add(I_RUN, 0, F_RUN, 3);
    for (int i = 1; i <= 15; i++) add(I_RUN | I_INC, i, F_RUN, 3);
    add(I_RUN | I_INC, 15, F_FLT, 3);
    add(I_RUN | I_INC | I_RST, 15, F_FLT, 3);
    add(I_CF, 0, 4'b0000, 3);
    // SC_reset beats SC_inc; then HALT beats SC_reset at step 5.
    add(I_RUN, 0, F_RUN, 3);
    add(I_RUN | I_INC, 1, F_RUN, 3);
    add(I_RUN | I_INC | I_RST, 0, F_RUN | F_DONE, 4);
    for (int i = 1; i <= 5; i++) add(I_RUN | I_INC, i, F_RUN, 4);
    add(I_RUN | I_HLT | I_RST, 5, F_HALT, 4);
    add(I_RUN | I_SS | I_CF | I_INC, 5, F_HALT, 4);
    add(I_SS | I_RST, 5, F_HALT, 4);
    add(I_CF, 5, F_HALT, 4);

    drive(6'b0);
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_both("reset", 0, 4'b0000, 0);
    reset_n = 1'b1;

    foreach (tbl[i]) begin
      drive(tbl[i].in);
      @(posedge clk);
      #1;
      check_both($sformatf("tbl%0d", i), tbl[i].step, tbl[i].flags, tbl[i].count);
    end

    // Only reset leaves HALTED; then an async reset in the middle of an instruction.
    async_reset_check("halt_exit");
    drive(I_RUN);
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) begin drive(I_RUN | I_INC); @(posedge clk); #1; end
    check_both("mid_instr", 4, F_RUN, 0);
    async_reset_check("async_mid");

    // Retire 17 instructions back to back: the 4-bit counter wraps to 1.
    drive(I_RUN);
    @(posedge clk); #1;
    for (int i = 0; i < 17; i++) begin drive(I_RUN | I_RST); @(posedge clk); #1; end
    check_both("wrap17", 0, F_RUN | F_DONE, 17);
    async_reset_check("pre_random");

    // Random phase against the model.
    cr_hold = 1'b0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      if (($urandom % 300 == 0) || (m_halted && ($urandom % 8 == 0)))
        async_reset_check($sformatf("rnd_reset%0d", cyc));
      if ($urandom % 10 == 0) cr_hold = ~cr_hold;
      in = {cr_hold, ($urandom % 8 == 0), ($urandom % 6 == 0),
            ($urandom % 3 != 0), ($urandom % 14 == 0), ($urandom % 80 == 0)};
      drive(in);
      @(posedge clk);
      #1;
      model_clock(in);
      check_both($sformatf("rnd%0d", cyc), m_step,
                 {m_running | m_single, m_halted, m_faulted, m_done}, m_count);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
